// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, the ROB entry layout and the free-eligibility helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rob_pkg;

  localparam int DEPTH    = 16;
  localparam int PREG_W   = 6;
  localparam int NUM_PREG = 1 << PREG_W;

  // old_dr value meaning "destination had no previous physical mapping"
  localparam logic [PREG_W:0] NO_OLD_PREG = NUM_PREG[PREG_W:0];

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] dr_p;
    logic [PREG_W:0]   old_dr;
  } rob_entry_t;

  // An old mapping is returned to the pool only if it names a real preg other than x0's
  function automatic logic frees_preg(input logic [PREG_W:0] old_dr);
    return (old_dr < NO_OLD_PREG) && (old_dr != '0);
  endfunction

endpackage

// File: rtl/rob_free_decode.sv
// rob_free_decode: turns up to two retiring (valid, old_dr) pairs into a one-hot-per-preg free vector.
// Latency: purely combinational.
// Backpressure: none; a duplicate preg simply sets the same bit once.
module rob_free_decode
  import rob_pkg::*;
(
  input  logic                v0,
  input  logic [PREG_W:0]     old0,
  input  logic                v1,
  input  logic [PREG_W:0]     old1,
  output logic [NUM_PREG-1:0] free_vec
);

  // OR both retiring slots into the vector, skipping x0 and "no old preg"
  always_comb begin
    free_vec = '0;
    if (v0 && frees_preg(old0)) free_vec[old0[PREG_W-1:0]] = 1'b1;
    if (v1 && frees_preg(old1)) free_vec[old1[PREG_W-1:0]] = 1'b1;
  end

endmodule

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer; retires done head entries and frees their old pregs.
// Latency: completion lands at one edge, retire at the next; free vector and count are registered.
// Backpressure: alloc_ready low while full (even if the head retires that cycle); unready allocs dropped.
// Build option: define ROB_DUAL_RETIRE_EN to retire head and head+1 on the same edge.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     alloc_valid,
  input  logic [PREG_W-1:0]        alloc_dr_p,
  input  logic [PREG_W:0]          alloc_old_dr,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_rob_num,
  input  logic                     cmpl_valid,
  input  logic [$clog2(DEPTH)-1:0] cmpl_rob_num,
  output logic [(1<<PREG_W)-1:0]   retire_from_ROB,
  output logic [1:0]               retire_cnt,
  output logic                     rob_empty
);
  import rob_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  rob_entry_t              ent [DEPTH];
  logic [IW-1:0]           head;
  logic [IW-1:0]           tail;
  logic [OW-1:0]           occ;
  logic                    alloc_fire;
  logic                    ret0;
  logic                    ret1;
  logic [1:0]              ret_n;
  logic [PREG_W:0]         old1;
  logic [(1<<PREG_W)-1:0]  free_vec;
  logic                    dr_p_unused;

  // Full check uses the registered occupancy only, so a same-cycle retire never opens a slot early
  assign alloc_ready   = (occ != OW'(DEPTH));
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign alloc_rob_num = tail;
  assign rob_empty     = (occ == '0);

  // Head retires on the registered done bit, so a completion is always visible for a cycle first
  assign ret0 = ent[head].valid && ent[head].done;

`ifdef ROB_DUAL_RETIRE_EN
  logic [IW-1:0] head_nx1;
  assign head_nx1 = head + IW'(1);
  assign ret1     = ret0 && ent[head_nx1].valid && ent[head_nx1].done;
  assign old1     = ent[head_nx1].old_dr;
`else
  assign ret1 = 1'b0;
  assign old1 = '0;
`endif

  assign ret_n = {1'b0, ret0} + {1'b0, ret1};

  rob_free_decode u_free_decode (
    .v0       (ret0),
    .old0     (ent[head].old_dr),
    .v1       (ret1),
    .old1     (old1),
    .free_vec (free_vec)
  );

  // dr_p rides along for the rename side and is not consumed by retirement
  always_comb begin
    dr_p_unused = 1'b0;
    for (int i = 0; i < DEPTH; i++) dr_p_unused = dr_p_unused ^ (^ent[i].dr_p);
  end

  // Entry array: completion, then alloc write, then retire clear (they never collide on one valid slot)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (cmpl_valid && ent[cmpl_rob_num].valid) ent[cmpl_rob_num].done <= 1'b1;
      if (alloc_fire) ent[tail] <= '{valid: 1'b1, done: 1'b0, dr_p: alloc_dr_p, old_dr: alloc_old_dr};
      if (ret0) ent[head].valid <= 1'b0;
`ifdef ROB_DUAL_RETIRE_EN
      if (ret1) ent[head_nx1].valid <= 1'b0;
`endif
    end
  end

  // Pointers, occupancy and the registered retire report
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head            <= '0;
      tail            <= '0;
      occ             <= '0;
      retire_from_ROB <= '0;
      retire_cnt      <= 2'd0;
    end else begin
      head            <= head + IW'(ret_n);
      tail            <= tail + IW'(alloc_fire);
      occ             <= occ + OW'(alloc_fire) - OW'(ret_n);
      retire_from_ROB <= free_vec;
      retire_cnt      <= ret_n;
    end
  end

endmodule
